bw_clk_cken_seq_jbus: RTL and testbench



---
 rtl/bw_clk_seq_pkg.sv | 44 ++++
 rtl/bw_clk_seq_dly_cnt.sv | 31 +++
 rtl/bw_clk_cken_seq_jbus.sv | 193 +++++++++++++++++++
 tb/tb_bw_clk_cken_seq_jbus.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bw_clk_seq_pkg.sv
// Shared state encoding and sizing helpers for the jbus cluster clock-enable sequencer.
package bw_clk_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RST_HOLD,
        ST_RUN,
        ST_DBG,
        ST_RST_DRAIN,
        ST_RAMP_DN
    } seq_state_e;

    localparam int unsigned DEF_NUM_CLUST   = 4;
    localparam int unsigned DEF_STAGGER_CYC = 4;
    localparam int unsigned DEF_GRST_DLY    = 8;
    localparam int unsigned DEF_DBG_PULSE   = 16;

    // Counter holds (delay - 1), so clog2 of the largest delay is always wide enough.
    function automatic int unsigned cnt_width(input int unsigned stagger,
                                              input int unsigned hold,
                                              input int unsigned pulse);
        int unsigned m;
        int unsigned w;
        m = stagger;
        if (hold > m)  m = hold;
        if (pulse > m) m = pulse;
        w = $clog2(m);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned slot_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic is_busy(input seq_state_e s);
        return !((s == ST_IDLE) || (s == ST_RUN));
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_STAGGER_CYC, DEF_GRST_DLY, DEF_DBG_PULSE);

endpackage

// File: rtl/bw_clk_seq_dly_cnt.sv
// Loadable down-counter; done pulses for one cycle after (load_val + 1) cycles.
module bw_clk_seq_dly_cnt
    import bw_clk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CNT_W
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            done  <= (load_val == '0);
        end else if (count != '0) begin
            count <= count - 1'b1;
            done  <= (count == WIDTH'(1));
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/bw_clk_cken_seq_jbus.sv
// Jbus cluster cken / grst_l / gdbginit_l sequencer with staggered start and reverse stop.
// Optional debug-pulse counter output dbg_cnt under `BW_CLK_CKEN_SEQ_DBGCNT_EN.
module bw_clk_cken_seq_jbus
    import bw_clk_seq_pkg::*;
#(
    parameter int unsigned NUM_CLUST   = DEF_NUM_CLUST,
    parameter int unsigned STAGGER_CYC = DEF_STAGGER_CYC,
    parameter int unsigned GRST_DLY    = DEF_GRST_DLY,
    parameter int unsigned DBG_PULSE   = DEF_DBG_PULSE
) (
    input  logic                 rclk,
    input  logic                 arst_l,
    input  logic                 start_req,
    input  logic                 stop_req,
    input  logic                 dbg_req,
    input  logic [NUM_CLUST-1:0] cken_mask,
    output logic [NUM_CLUST-1:0] cluster_cken,
    output logic                 grst_l,
    output logic                 gdbginit_l,
    output logic                 start_ack,
    output logic                 stop_ack,
    output logic                 busy
`ifdef BW_CLK_CKEN_SEQ_DBGCNT_EN
    ,
    output logic [7:0]           dbg_cnt
`endif
);

    localparam int unsigned CNT_W  = cnt_width(STAGGER_CYC, GRST_DLY, DBG_PULSE);
    localparam int unsigned SLOT_W = slot_width(NUM_CLUST);

    localparam logic [CNT_W-1:0]  STG_LD    = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0]  GRST_LD   = CNT_W'(GRST_DLY - 1);
    localparam logic [CNT_W-1:0]  DBG_LD    = CNT_W'(DBG_PULSE - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CLUST - 1);

    seq_state_e           state, state_nxt;
    logic [SLOT_W-1:0]    slot, slot_nxt;
    logic [NUM_CLUST-1:0] mask, mask_nxt;
    logic [NUM_CLUST-1:0] cken_nxt;
    logic                 grst_nxt, gdbg_nxt;
    logic                 start_ack_nxt, stop_ack_nxt, busy_nxt;
    logic                 ld;
    logic [CNT_W-1:0]     ld_val;
    logic                 done;

    bw_clk_seq_dly_cnt #(
        .WIDTH (CNT_W)
    ) u_dly_cnt (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .load     (ld),
        .load_val (ld_val),
        .done     (done)
    );

    always_comb begin
        state_nxt     = state;
        slot_nxt      = slot;
        mask_nxt      = mask;
        cken_nxt      = cluster_cken;
        grst_nxt      = grst_l;
        gdbg_nxt      = gdbginit_l;
        start_ack_nxt = 1'b0;
        stop_ack_nxt  = 1'b0;
        ld            = 1'b0;
        ld_val        = STG_LD;

        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_RAMP_UP;
                    mask_nxt  = cken_mask;
                    slot_nxt  = '0;
                    ld        = 1'b1;
                    ld_val    = STG_LD;
                end
            end
            ST_RAMP_UP: begin
                if (done) begin
                    cken_nxt[slot] = ~mask[slot];
                    ld             = 1'b1;
                    if (slot == LAST_SLOT) begin
                        state_nxt = ST_RST_HOLD;
                        ld_val    = GRST_LD;
                    end else begin
                        slot_nxt  = slot + 1'b1;
                        ld_val    = STG_LD;
                    end
                end
            end
            ST_RST_HOLD: begin
                if (done) begin
                    state_nxt     = ST_RUN;
                    grst_nxt      = 1'b1;
                    gdbg_nxt      = 1'b1;
                    start_ack_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                gdbg_nxt = 1'b1;
                if (stop_req) begin
                    state_nxt = ST_RST_DRAIN;
                    ld        = 1'b1;
                    ld_val    = GRST_LD;
                end else if (dbg_req) begin
                    state_nxt = ST_DBG;
                    ld        = 1'b1;
                    ld_val    = DBG_LD;
                end
            end
            ST_DBG: begin
                // gdbginit_l follows the state one edge late, so the pulse spans edges 1..DBG_PULSE.
                gdbg_nxt = 1'b0;
                if (stop_req) begin
                    state_nxt = ST_RST_DRAIN;
                    ld        = 1'b1;
                    ld_val    = GRST_LD;
                end else if (done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RST_DRAIN: begin
                grst_nxt = 1'b0;
                gdbg_nxt = 1'b0;
                if (done) begin
                    state_nxt = ST_RAMP_DN;
                    slot_nxt  = LAST_SLOT;
                    ld        = 1'b1;
                    ld_val    = STG_LD;
                end
            end
            ST_RAMP_DN: begin
                grst_nxt = 1'b0;
                gdbg_nxt = 1'b0;
                if (done) begin
                    cken_nxt[slot] = 1'b0;
                    if (slot == '0) begin
                        state_nxt    = ST_IDLE;
                        stop_ack_nxt = 1'b1;
                    end else begin
                        slot_nxt = slot - 1'b1;
                        ld       = 1'b1;
                        ld_val   = STG_LD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Busy rises one edge after leaving IDLE/RUN and drops on the edge that returns there.
        busy_nxt = is_busy(state) && is_busy(state_nxt);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state        <= ST_IDLE;
            slot         <= '0;
            mask         <= '0;
            cluster_cken <= '0;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            start_ack    <= 1'b0;
            stop_ack     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            slot         <= slot_nxt;
            mask         <= mask_nxt;
            cluster_cken <= cken_nxt;
            grst_l       <= grst_nxt;
            gdbginit_l   <= gdbg_nxt;
            start_ack    <= start_ack_nxt;
            stop_ack     <= stop_ack_nxt;
            busy         <= busy_nxt;
        end
    end

`ifdef BW_CLK_CKEN_SEQ_DBGCNT_EN
    logic dbg_done;

    assign dbg_done = (state == ST_DBG) && done && !stop_req;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            dbg_cnt <= '0;
        end else if (dbg_done && (dbg_cnt != 8'hFF)) begin
            dbg_cnt <= dbg_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bw_clk_cken_seq_jbus.sv
// Directed self-checking bench for bw_clk_cken_seq_jbus at default parameters.
module tb_bw_clk_cken_seq_jbus;

    logic       rclk = 1'b0;
    logic       arst_l;
    logic       start_req, stop_req, dbg_req;
    logic [3:0] cken_mask;
    logic [3:0] cluster_cken;
    logic       grst_l, gdbginit_l, start_ack, stop_ack, busy;
`ifdef BW_CLK_CKEN_SEQ_DBGCNT_EN
    logic [7:0] dbg_cnt;
`endif

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    bw_clk_cken_seq_jbus #(
        .NUM_CLUST   (4),
        .STAGGER_CYC (4),
        .GRST_DLY    (8),
        .DBG_PULSE   (16)
    ) dut (
        .rclk         (rclk),
        .arst_l       (arst_l),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .dbg_req      (dbg_req),
        .cken_mask    (cken_mask),
        .cluster_cken (cluster_cken),
        .grst_l       (grst_l),
        .gdbginit_l   (gdbginit_l),
        .start_ack    (start_ack),
        .stop_ack     (stop_ack),
        .busy         (busy)
`ifdef BW_CLK_CKEN_SEQ_DBGCNT_EN
        ,
        .dbg_cnt      (dbg_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // {cken[3:0], grst_l, gdbginit_l, start_ack, stop_ack, busy}
    function automatic logic [31:0] status();
        return {23'd0, cluster_cken, grst_l, gdbginit_l, start_ack, stop_ack, busy};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] ck, input logic g, input logic d,
                                         input logic sa, input logic so, input logic b);
        return {23'd0, ck, g, d, sa, so, b};
    endfunction

    // Ramp-up: cken[i] at 4*(i+1), release at 24, busy on edges 1..23.
    function automatic logic [31:0] exp_up(input int k, input logic [3:0] m);
        logic [3:0] ck;
        for (int i = 0; i < 4; i++) ck[i] = (k >= 4 * (i + 1)) && !m[i];
        return pack(ck, k >= 24, k >= 24, k == 24, 1'b0, (k >= 1) && (k <= 23));
    endfunction

    // Stop sampled at edge s (relative to origin, dbg at origin if dbg=1):
    // cken[i] falls at s+8+4*(4-i), stop_ack at s+24.
    function automatic logic [31:0] exp_dn(input int k, input logic [3:0] m, input int s, input logic dbg);
        logic [3:0] ck;
        logic       b;
        for (int i = 0; i < 4; i++) ck[i] = !m[i] && (k < s + 8 + 4 * (4 - i));
        b = dbg ? ((k >= 1) && (k <= s + 23)) : ((k >= s + 1) && (k <= s + 23));
        return pack(ck, k <= s, dbg ? (k == 0) : (k <= s), 1'b0, k == s + 24, b);
    endfunction

    task automatic run_up(input logic [3:0] m, input logic with_stop, input string nm);
        cken_mask = m;
        start_req = 1'b1;
        stop_req  = with_stop;
        tick();
        start_req = 1'b0;
        stop_req  = 1'b0;
        cken_mask = ~m;
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) tick();
            check($sformatf("%s_e%0d", nm, k), status(), exp_up(k, m));
        end
    endtask

    task automatic run_dn(input logic [3:0] m, input int late_start, input string nm);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        check($sformatf("%s_e0", nm), status(), exp_dn(0, m, 0, 1'b0));
        for (int k = 1; k <= 32; k++) begin
            start_req = (k == late_start);
            tick();
            start_req = 1'b0;
            check($sformatf("%s_e%0d", nm, k), status(), exp_dn(k, m, 0, 1'b0));
        end
    endtask

    initial begin
        arst_l    = 1'b0;
        start_req = 1'b0;
        stop_req  = 1'b0;
        dbg_req   = 1'b0;
        cken_mask = 4'h0;
        tick();
        tick();
        check("rst_state", status(), 32'd0);
        arst_l = 1'b1;
        tick();
        check("idle_after_rst", status(), 32'd0);

        // dbg_req and stop_req are ignored in IDLE
        dbg_req  = 1'b1;
        stop_req = 1'b1;
        tick();
        dbg_req  = 1'b0;
        stop_req = 1'b0;
        tick();
        check("idle_ignores_req", status(), 32'd0);

        run_up(4'b0000, 1'b0, "up0");
        run_dn(4'b0000, 0, "dn0");

        run_up(4'b0101, 1'b0, "upm");

        // Plain debug pulse with a second dbg_req at edge 5 that must be ignored
        dbg_req = 1'b1;
        start_req = 1'b1;
        tick();
        dbg_req = 1'b0;
        start_req = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) begin
                dbg_req = (k == 5);
                tick();
                dbg_req = 1'b0;
            end
            check($sformatf("dbg_g_e%0d", k), {31'd0, gdbginit_l}, {31'd0, !((k >= 1) && (k <= 16))});
            check($sformatf("dbg_r_e%0d", k), {27'd0, cluster_cken, grst_l}, {27'd0, 4'b1010, 1'b1});
        end
        check("dbg_busy_done", {31'd0, busy}, 32'd0);
`ifdef BW_CLK_CKEN_SEQ_DBGCNT_EN
        check("dbg_cnt_one", {24'd0, dbg_cnt}, 32'd1);
`endif

        // Debug pulse aborted by stop at edge 8; gdbginit_l stays low through the stop
        dbg_req = 1'b1;
        tick();
        dbg_req = 1'b0;
        check("dbgstop_e0", status(), exp_dn(0, 4'b0101, 8, 1'b1));
        for (int k = 1; k <= 34; k++) begin
            dbg_req  = (k == 5);
            stop_req = (k == 8);
            tick();
            dbg_req  = 1'b0;
            stop_req = 1'b0;
            check($sformatf("dbgstop_e%0d", k), status(), exp_dn(k, 4'b0101, 8, 1'b1));
        end
`ifdef BW_CLK_CKEN_SEQ_DBGCNT_EN
        check("dbg_cnt_abort", {24'd0, dbg_cnt}, 32'd1);
`endif

        // start and stop together in IDLE: start wins; start during RAMP_DN dropped
        run_up(4'b0000, 1'b1, "upss");
        run_dn(4'b0000, 12, "dnls");

        // Asynchronous reset mid ramp-up
        cken_mask = 4'b0000;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        check("pre_arst", status(), exp_up(10, 4'b0000));
        arst_l = 1'b0;
        #1;
        check("arst_async", status(), 32'd0);
        tick();
        tick();
        arst_l = 1'b1;
        tick();
        tick();
        check("post_arst_idle", status(), 32'd0);
        run_up(4'b0000, 1'b0, "uprst");
        run_dn(4'b0000, 0, "dnrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
